mem_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and constants for the data-port memory arbiter.
//            arb_state_t  - ownership state of the shared port
//            master_id_t  - identifies one of the two masters
//            M0 / M1      - CPU data port / boot-debug loader
//            PERIPH_BASE_DEF - start of the I/O region the loader may not reach
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef logic master_id_t;

    localparam master_id_t  M0              = 1'b0;
    localparam master_id_t  M1              = 1'b1;
    localparam logic [31:0] PERIPH_BASE_DEF = 32'hC000_0000;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin arbiter sharing the data side of the unified memory
//            between the CPU (M0) and the boot/debug loader (M1), with a
//            bounded burst per owner and a loader block on the I/O region.
// Ports    : clk, reset_n          - clock, asynchronous active-low reset
//            m0_req/we/addr/wd     - CPU access request
//            m0_gnt/rd             - CPU grant and read data
//            m1_req/we/addr/wd     - loader access request
//            m1_gnt/rd/err         - loader grant, read data, region reject
//            mem_we/a/wd           - to memory (write enable, address, data)
//            mem_rd                - from memory (combinational read data)
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST   = 4,
    parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wd,
    output logic        m0_gnt,
    output logic [31:0] m0_rd,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wd,
    output logic        m1_gnt,
    output logic [31:0] m1_rd,
    output logic        m1_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    arb_state_t state_q,       state_d;
    master_id_t last_served_q, last_served_d;
    logic [3:0] beat_cnt_q,    beat_cnt_d;

    // View of the bus from the current owner's side; only meaningful in OWNx.
    master_id_t owner_id;
    logic       owner_req;
    logic       other_req;
    arb_state_t other_state;
    logic       m1_blocked;

    assign owner_id    = (state_q == OWN1) ? M1 : M0;
    assign owner_req   = (owner_id == M1) ? m1_req : m0_req;
    assign other_req   = (owner_id == M1) ? m0_req : m1_req;
    assign other_state = (owner_id == M1) ? OWN0 : OWN1;
    assign m1_blocked  = (m1_addr >= PERIPH_BASE);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            last_served_q <= M1;    // M0 wins the first tie
            beat_cnt_q    <= 4'd0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            beat_cnt_q    <= beat_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state: ownership, fairness pointer and burst counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        beat_cnt_d    = beat_cnt_q;
        case (state_q)
            IDLE: begin
                beat_cnt_d = 4'd0;
                if (m0_req && m1_req) begin
                    state_d = (last_served_q == M1) ? OWN0 : OWN1;
                end else if (m0_req) begin
                    state_d = OWN0;
                end else if (m1_req) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (owner_req) begin
                    if (beat_cnt_q == BURST_LAST) begin
                        // Burst exhausted: hand over only if someone waits,
                        // otherwise start a fresh burst for the same owner.
                        beat_cnt_d = 4'd0;
                        if (other_req) begin
                            state_d       = other_state;
                            last_served_d = owner_id;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 4'd1;
                    end
                end else begin
                    // Owner went quiet: this dead cycle releases the bus.
                    last_served_d = owner_id;
                    beat_cnt_d    = 4'd0;
                    state_d       = other_req ? other_state : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output mux: pure function of ownership and live master inputs
    // ------------------------------------------------------------------
    always_comb begin
        m0_gnt = 1'b0;
        m0_rd  = 32'd0;
        m1_gnt = 1'b0;
        m1_rd  = 32'd0;
        m1_err = 1'b0;
        mem_we = 1'b0;
        mem_a  = 32'd0;
        mem_wd = 32'd0;
        case (state_q)
            OWN0: begin
                if (m0_req) begin
                    mem_a  = m0_addr;
                    mem_wd = m0_wd;
                    mem_we = m0_we;
                    m0_gnt = 1'b1;
                    m0_rd  = mem_rd;
                end
            end
            OWN1: begin
                if (m1_req) begin
                    mem_a  = m1_addr;
                    mem_wd = m1_wd;
                    if (m1_blocked) begin
                        // Rejected beat: no write, no data, but it still
                        // consumes a slot of the burst.
                        m1_err = 1'b1;
                    end else begin
                        mem_we = m1_we;
                        m1_gnt = 1'b1;
                        m1_rd  = mem_rd;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule : mem_arbiter
`default_nettype wire
